// File: rtl/fetch_issue_buffer_if.sv
// Handshake bundle between the fetch frontend, the issue buffer and the dual-issue decoder.
// master = frontend/decoder side, slave = buffer side.
interface fetch_issue_buffer_if #(
  parameter int unsigned VLEN = 32,
  parameter int unsigned CF_W = 3
);
  logic                      fetch_valid;
  logic [31:0]               fetch_instr;
  logic [VLEN-1:0]           fetch_addr;
  logic [CF_W-1:0]           fetch_cf_type;
  logic [VLEN-1:0]           fetch_pred_addr;
  logic                      fetch_ready;

  logic [1:0]                issue_valid;
  logic [1:0][31:0]          issue_instr;
  logic [1:0][VLEN-1:0]      issue_addr;
  logic [1:0][CF_W-1:0]      issue_cf_type;
  logic [1:0][VLEN-1:0]      issue_pred_addr;
  logic [1:0]                issue_ack;

  modport master (
    output fetch_valid, fetch_instr, fetch_addr, fetch_cf_type, fetch_pred_addr,
    input  fetch_ready,
    input  issue_valid, issue_instr, issue_addr, issue_cf_type, issue_pred_addr,
    output issue_ack
  );

  modport slave (
    input  fetch_valid, fetch_instr, fetch_addr, fetch_cf_type, fetch_pred_addr,
    output fetch_ready,
    output issue_valid, issue_instr, issue_addr, issue_cf_type, issue_pred_addr,
    input  issue_ack
  );
endinterface

// File: rtl/fetch_issue_buffer.sv
// Decoupling FIFO between fetch and the dual-issue decoder: one push per cycle,
// oldest two entries presented as an issue pair, 0/1/2 retired per cycle, flushable.
module fetch_issue_buffer #(
  parameter int unsigned VLEN  = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CF_W  = 3
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  fetch_issue_buffer_if.slave          bus,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam logic [CF_W-1:0] NO_CF = '0;

  logic [31:0]     instr_q [DEPTH];
  logic [VLEN-1:0] addr_q  [DEPTH];
  logic [CF_W-1:0] cf_q    [DEPTH];
  logic [VLEN-1:0] pred_q  [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q, rd_ptr_nx1;
  logic [CNT_W-1:0] count_q;
  logic             push, pop0, pop1;
  logic [1:0]       pop_n;

  assign rd_ptr_nx1      = rd_ptr_q + PTR_W'(1);
  assign bus.fetch_ready = (count_q < CNT_W'(DEPTH));
  assign push            = bus.fetch_valid & bus.fetch_ready;

  // A control-flow entry in the oldest slot must issue alone.
  assign bus.issue_valid[0] = (count_q != '0);
  assign bus.issue_valid[1] = (count_q >= CNT_W'(2)) && (cf_q[rd_ptr_q] == NO_CF);

  assign bus.issue_instr[0]     = instr_q[rd_ptr_q];
  assign bus.issue_instr[1]     = instr_q[rd_ptr_nx1];
  assign bus.issue_addr[0]      = addr_q[rd_ptr_q];
  assign bus.issue_addr[1]      = addr_q[rd_ptr_nx1];
  assign bus.issue_cf_type[0]   = cf_q[rd_ptr_q];
  assign bus.issue_cf_type[1]   = cf_q[rd_ptr_nx1];
  assign bus.issue_pred_addr[0] = pred_q[rd_ptr_q];
  assign bus.issue_pred_addr[1] = pred_q[rd_ptr_nx1];

  // Slot1 ack counts only together with slot0 ack, so the illegal 10 pattern retires nothing.
  assign pop0  = bus.issue_ack[0] & bus.issue_valid[0];
  assign pop1  = bus.issue_ack[1] & bus.issue_ack[0] & bus.issue_valid[1];
  assign pop_n = {1'b0, pop0} + {1'b0, pop1};

  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      rd_ptr_q <= rd_ptr_q + PTR_W'(pop_n);
      count_q  <= count_q + CNT_W'(push) - CNT_W'(pop_n);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_q[wr_ptr_q] <= bus.fetch_instr;
      addr_q[wr_ptr_q]  <= bus.fetch_addr;
      cf_q[wr_ptr_q]    <= bus.fetch_cf_type;
      pred_q[wr_ptr_q]  <= bus.fetch_pred_addr;
    end
  end

  a_count_le_depth : assert property (@(posedge clk_i) disable iff (rst_i)
    count_q <= CNT_W'(DEPTH));
  a_slot_order : assert property (@(posedge clk_i) disable iff (rst_i)
    bus.issue_valid[1] |-> bus.issue_valid[0]);
  a_ack_legal : assert property (@(posedge clk_i) disable iff (rst_i)
    bus.issue_ack != 2'b10);
  a_push_ready : assert property (@(posedge clk_i) disable iff (rst_i)
    push |-> bus.fetch_ready);

endmodule

// File: tb/tb_fetch_issue_buffer.sv
// Directed and scoreboard-driven random checks for fetch_issue_buffer (DEPTH=4).
module tb_fetch_issue_buffer;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       flush_i;
  logic [2:0] count_o;

  int unsigned n_checks = 0;
  int unsigned n_bad    = 0;

  fetch_issue_buffer_if #(.VLEN(32), .CF_W(3)) bus ();

  fetch_issue_buffer #(.VLEN(32), .DEPTH(4), .CF_W(3)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .bus     (bus.slave),
    .count_o (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_fetch(input logic v, input logic [31:0] instr, input logic [31:0] addr,
                           input logic [2:0] cf, input logic [31:0] pred);
    bus.fetch_valid     = v;
    bus.fetch_instr     = instr;
    bus.fetch_addr      = addr;
    bus.fetch_cf_type   = cf;
    bus.fetch_pred_addr = pred;
  endtask

  logic [31:0] mq_addr [$];
  logic [2:0]  mq_cf   [$];

  initial begin
    logic       fv, fl, mv0, mv1, mready;
    logic [1:0] ack;
    logic [2:0] cf;
    int unsigned npop;
    logic [31:0] next_addr;

    rst_i = 1'b1;
    flush_i = 1'b0;
    bus.issue_ack = 2'b00;
    set_fetch(1'b0, '0, '0, '0, '0);
    step();
    step();
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_ready", 64'(bus.fetch_ready), 64'd1);
    check("rst_valid", 64'(bus.issue_valid), 64'd0);

    // T1: single push, visible next cycle only
    rst_i = 1'b0;
    set_fetch(1'b1, 32'h00000013, 32'h80000000, 3'd0, 32'h0);
    check("t1_no_bypass", 64'(bus.issue_valid), 64'd0);
    step();
    set_fetch(1'b0, '0, '0, '0, '0);
    check("t1_valid", 64'(bus.issue_valid), 64'd1);
    check("t1_count", 64'(count_o), 64'd1);
    check("t1_addr0", 64'(bus.issue_addr[0]), 64'h80000000);
    check("t1_instr0", 64'(bus.issue_instr[0]), 64'h00000013);

    // Reset mid-stream discards the entry
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check("midrst_count", 64'(count_o), 64'd0);
    check("midrst_valid", 64'(bus.issue_valid), 64'd0);

    // T2: fill to full, 5th push refused
    for (int i = 0; i < 4; i++) begin
      set_fetch(1'b1, 32'hA0 + 32'(i), 32'h1000 + 32'(4*i), 3'd0, 32'h0);
      step();
      check("t2_count", 64'(count_o), 64'(i + 1));
    end
    check("t2_ready_full", 64'(bus.fetch_ready), 64'd0);
    set_fetch(1'b1, 32'hA4, 32'h1010, 3'd0, 32'h0);
    step();
    check("t2_count_held", 64'(count_o), 64'd4);
    check("t2_valid", 64'(bus.issue_valid), 64'd3);
    check("t2_addr0", 64'(bus.issue_addr[0]), 64'h1000);
    check("t2_addr1", 64'(bus.issue_addr[1]), 64'h1004);

    // T3: dual retire while full (push still blocked that cycle), then wrap
    bus.issue_ack = 2'b11;
    step();
    check("t3_count_a", 64'(count_o), 64'd2);
    check("t3_ready_a", 64'(bus.fetch_ready), 64'd1);
    check("t3_addr0_a", 64'(bus.issue_addr[0]), 64'h1008);
    check("t3_addr1_a", 64'(bus.issue_addr[1]), 64'h100C);
    step();
    check("t3_count_b", 64'(count_o), 64'd1);
    check("t3_addr0_b", 64'(bus.issue_addr[0]), 64'h1010);
    check("t3_instr0_b", 64'(bus.issue_instr[0]), 64'hA4);
    set_fetch(1'b1, 32'hA5, 32'h1014, 3'd0, 32'h0);
    bus.issue_ack = 2'b01;
    step();
    check("t3_count_c", 64'(count_o), 64'd1);
    check("t3_addr0_c", 64'(bus.issue_addr[0]), 64'h1014);
    set_fetch(1'b0, '0, '0, '0, '0);
    step();
    bus.issue_ack = 2'b00;
    check("t3_drained", 64'(count_o), 64'd0);

    // T4: branch in slot0 issues alone
    set_fetch(1'b1, 32'hB0, 32'h2000, 3'd1, 32'h80000100);
    step();
    set_fetch(1'b1, 32'hB1, 32'h2004, 3'd0, 32'h0);
    step();
    set_fetch(1'b0, '0, '0, '0, '0);
    check("t4_count", 64'(count_o), 64'd2);
    check("t4_valid_cf", 64'(bus.issue_valid), 64'd1);
    check("t4_cf0", 64'(bus.issue_cf_type[0]), 64'd1);
    check("t4_pred0", 64'(bus.issue_pred_addr[0]), 64'h80000100);
    bus.issue_ack = 2'b01;
    step();
    bus.issue_ack = 2'b00;
    check("t4_valid_after", 64'(bus.issue_valid), 64'd1);
    check("t4_addr0_after", 64'(bus.issue_addr[0]), 64'h2004);
    set_fetch(1'b1, 32'hB2, 32'h2008, 3'd2, 32'h2200);
    step();
    set_fetch(1'b0, '0, '0, '0, '0);
    check("t4_cf_young_ok", 64'(bus.issue_valid), 64'd3);
    check("t4_cf1", 64'(bus.issue_cf_type[1]), 64'd2);
    check("t4_addr1", 64'(bus.issue_addr[1]), 64'h2008);
    bus.issue_ack = 2'b11;
    step();
    check("t4_pair_pop", 64'(count_o), 64'd0);
    // ack=11 with one entry retires one; ack on empty is ignored
    bus.issue_ack = 2'b00;
    set_fetch(1'b1, 32'hB3, 32'h2100, 3'd0, 32'h0);
    step();
    set_fetch(1'b0, '0, '0, '0, '0);
    bus.issue_ack = 2'b11;
    step();
    check("single_ack11", 64'(count_o), 64'd0);
    step();
    check("empty_ack", 64'(count_o), 64'd0);
    check("empty_valid", 64'(bus.issue_valid), 64'd0);
    bus.issue_ack = 2'b00;

    // T5: flush beats simultaneous push and pop
    for (int i = 0; i < 3; i++) begin
      set_fetch(1'b1, 32'hC0 + 32'(i), 32'h3000 + 32'(4*i), 3'd0, 32'h0);
      step();
    end
    check("t5_count3", 64'(count_o), 64'd3);
    set_fetch(1'b1, 32'hC3, 32'h300C, 3'd0, 32'h0);
    bus.issue_ack = 2'b11;
    flush_i = 1'b1;
    check("t5_ready_flush", 64'(bus.fetch_ready), 64'd1);
    step();
    flush_i = 1'b0;
    bus.issue_ack = 2'b00;
    set_fetch(1'b0, '0, '0, '0, '0);
    check("t5_count", 64'(count_o), 64'd0);
    check("t5_valid", 64'(bus.issue_valid), 64'd0);
    step();
    step();
    check("t5_dropped", 64'(bus.issue_valid), 64'd0);

    // T6: random traffic against a queue model
    next_addr = 32'h4000;
    for (int c = 0; c < 300; c++) begin
      mv0 = (mq_addr.size() >= 1);
      mv1 = (mq_addr.size() >= 2) && (mq_cf[0] == 3'd0);
      check("t6_count", 64'(count_o), 64'(mq_addr.size()));
      check("t6_valid", 64'(bus.issue_valid), 64'({mv1, mv0}));
      if (mv0) check("t6_addr0", 64'(bus.issue_addr[0]), 64'(mq_addr[0]));
      if (mv1) check("t6_addr1", 64'(bus.issue_addr[1]), 64'(mq_addr[1]));

      fv = ($urandom_range(0, 3) != 0);
      cf = ($urandom_range(0, 3) == 0) ? 3'd1 : 3'd0;
      case ($urandom_range(0, 2))
        0:       ack = 2'b00;
        1:       ack = 2'b01;
        default: ack = 2'b11;
      endcase
      fl = ($urandom_range(0, 19) == 0);
      set_fetch(fv, ~next_addr, next_addr, cf, next_addr + 32'h40);
      bus.issue_ack = ack;
      flush_i = fl;

      if (fl) begin
        mq_addr.delete();
        mq_cf.delete();
      end else begin
        mready = (mq_addr.size() < 4);
        npop = 0;
        if (ack[0] && mv0) npop++;
        if (ack[0] && ack[1] && mv1) npop++;
        for (int k = 0; k < int'(npop); k++) begin
          void'(mq_addr.pop_front());
          void'(mq_cf.pop_front());
        end
        if (fv && mready) begin
          mq_addr.push_back(next_addr);
          mq_cf.push_back(cf);
        end
      end
      if (fv) next_addr = next_addr + 32'd4;
      step();
    end
    flush_i = 1'b0;
    bus.issue_ack = 2'b00;
    set_fetch(1'b0, '0, '0, '0, '0);
    check("t6_final_count", 64'(count_o), 64'(mq_addr.size()));

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
